// File: rtl/ef_smsdac_dwa.sv
// Mismatch-shaping element selector for the 8-unit-element DAC: converts a 0..8 count into an
// enable word whose set bits rotate (DWA, bidirectional DWA or LFSR-randomised start).
module ef_smsdac_dwa #(
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [3:0] din,
  output logic [7:0] q,
  output logic [2:0] ptr_o,
  output logic       sat
);

  localparam logic [1:0] ModeStatic = 2'd0;
  localparam logic [1:0] ModeDwa    = 2'd1;
  localparam logic [1:0] ModeBidir  = 2'd2;
  localparam logic [1:0] ModeRandom = 2'd3;

  localparam logic DirFwd = 1'b0;

  logic [7:0] q_q, q_d;
  logic [2:0] ptr_q, ptr_d;
  logic       dir_q, dir_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic       sat_q, sat_d;

  logic       over;
  logic [3:0] n;
  logic [2:0] n_mod;
  logic [7:0] thermo;
  logic [2:0] start;
  logic [7:0] rot;
  logic       lfsr_fb;

  assign over  = (din > 4'd8);
  assign n     = over ? 4'd8 : din;
  assign n_mod = n[2:0];

  always_comb begin
    thermo = 8'h00;
    case (n)
      4'd0:    thermo = 8'h00;
      4'd1:    thermo = 8'h01;
      4'd2:    thermo = 8'h03;
      4'd3:    thermo = 8'h07;
      4'd4:    thermo = 8'h0F;
      4'd5:    thermo = 8'h1F;
      4'd6:    thermo = 8'h3F;
      4'd7:    thermo = 8'h7F;
      default: thermo = 8'hFF;
    endcase
  end

  // x^8 + x^6 + x^5 + x^4 + 1, shifted in at bit 0.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    start  = 3'd0;
    ptr_d  = ptr_q;
    dir_d  = dir_q;
    lfsr_d = lfsr_q;
    unique case (mode)
      ModeStatic: begin
        start = 3'd0;
      end
      ModeDwa: begin
        start = ptr_q;
        ptr_d = ptr_q + n_mod;
      end
      ModeBidir: begin
        // Backward run occupies ptr-n .. ptr-1, i.e. a forward run starting at ptr-n.
        if (dir_q == DirFwd) begin
          start = ptr_q;
          ptr_d = ptr_q + n_mod;
        end else begin
          start = ptr_q - n_mod;
          ptr_d = ptr_q - n_mod;
        end
        dir_d = ~dir_q;
      end
      ModeRandom: begin
        start  = lfsr_q[2:0];
        ptr_d  = lfsr_q[2:0] + n_mod;
        lfsr_d = {lfsr_q[6:0], lfsr_fb};
      end
      default: begin
        start = 3'd0;
      end
    endcase
  end

  // Rotate-left of the thermometer word by the start position.
  assign rot   = (thermo << start) | (thermo >> (4'd8 - {1'b0, start}));
  assign q_d   = rot;
  assign sat_d = over;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q_q    <= 8'h00;
      ptr_q  <= 3'd0;
      dir_q  <= DirFwd;
      lfsr_q <= LFSR_SEED;
      sat_q  <= 1'b0;
    end else if (en) begin
      q_q    <= q_d;
      ptr_q  <= ptr_d;
      dir_q  <= dir_d;
      lfsr_q <= lfsr_d;
      sat_q  <= sat_d;
    end
  end

  assign q     = q_q;
  assign ptr_o = ptr_q;
  assign sat   = sat_q;

endmodule
